// File: rtl/exibidor_sequencia.sv
// exibidor_sequencia: plays the stored game sequence out to the LEDs.
// Reads the synchronous sequence ROM from address 0 up to a limit latched at
// start. Each step lights the LEDs with the stored value for T_ON cycles and
// then blanks them for T_OFF cycles. A one-cycle pronto pulse marks the end.
// Optional build macro EXIBIDOR_PAUSA_EN adds a pausa input that freezes the
// lit/dark timing while it is high.
module exibidor_sequencia #(
    parameter int T_ON  = 500,
    parameter int T_OFF = 250,
    parameter int CNT_W = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
`ifdef EXIBIDOR_PAUSA_EN
    input  logic       pausa,
`endif
    output logic [3:0] rom_endereco,
    input  logic [3:0] rom_dado,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        LE_ROM     = 3'd1,
        ESPERA_ROM = 3'd2,
        ACENDE     = 3'd3,
        APAGA      = 3'd4,
        FIM        = 3'd5
    } estado_t;

    localparam logic [CNT_W-1:0] C_ON_ULTIMO  = CNT_W'(T_ON - 1);
    localparam logic [CNT_W-1:0] C_OFF_ULTIMO = CNT_W'(T_OFF - 1);

    estado_t          r_estado;
    logic [CNT_W-1:0] r_timer;
    logic [3:0]       r_limite;
    logic [3:0]       r_dado;
    logic [3:0]       r_endereco;
    logic [3:0]       r_leds;
    logic             r_exibindo;
    logic             r_pronto;
    logic             w_pausa;

`ifdef EXIBIDOR_PAUSA_EN
    assign w_pausa = pausa;
`else
    assign w_pausa = 1'b0;
`endif

    // Sequencer FSM: state, step timer, address and all registered outputs.
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // the async reset clears every register, including data and limit latches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= OCIOSO;
            r_timer    <= '0;
            r_limite   <= '0;
            r_dado     <= '0;
            r_endereco <= '0;
            r_leds     <= '0;
            r_exibindo <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (iniciar) begin
                        r_endereco <= '0;
                        r_limite   <= limite;
                        r_exibindo <= 1'b1;
                        r_estado   <= LE_ROM;
                    end
                end
                // ROM registers the address on the edge leaving this state.
                LE_ROM: r_estado <= ESPERA_ROM;
                ESPERA_ROM: begin
                    r_dado   <= rom_dado;
                    r_leds   <= rom_dado;
                    r_timer  <= '0;
                    r_estado <= ACENDE;
                end
                ACENDE: begin
                    if (!w_pausa) begin
                        if (r_timer == C_ON_ULTIMO) begin
                            r_timer  <= '0;
                            r_leds   <= '0;
                            r_estado <= APAGA;
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                            r_leds  <= r_dado;
                        end
                    end
                end
                APAGA: begin
                    if (!w_pausa) begin
                        if (r_timer == C_OFF_ULTIMO) begin
                            r_timer <= '0;
                            // Limit compare ends the run before the address could wrap.
                            if (r_endereco == r_limite) begin
                                r_exibindo <= 1'b0;
                                r_pronto   <= 1'b1;
                                r_estado   <= FIM;
                            end else begin
                                r_endereco <= r_endereco + 4'd1;
                                r_estado   <= LE_ROM;
                            end
                        end else begin
                            r_timer <= r_timer + CNT_W'(1);
                        end
                    end
                end
                FIM: r_estado <= OCIOSO;
                // Codes 6 and 7 recover to idle with the outputs dark.
                default: begin
                    r_estado   <= OCIOSO;
                    r_leds     <= '0;
                    r_exibindo <= 1'b0;
                end
            endcase
        end
    end

    assign rom_endereco = r_endereco;
    assign leds         = r_leds;
    assign exibindo     = r_exibindo;
    assign pronto       = r_pronto;
    assign db_estado    = r_estado;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Bench for exibidor_sequencia with T_ON=3, T_OFF=2 (7-cycle steps).
// A per-cycle model derives every output from the step arithmetic; directed
// tests add literal expectations for latency, pronto timing and reset.
module tb_exibidor_sequencia;

    localparam int T_ON  = 3;
    localparam int T_OFF = 2;
    localparam int P     = 2 + T_ON + T_OFF;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] rom_endereco;
    logic [3:0] rom_dado = 4'd0;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [2:0] db_estado;
`ifdef EXIBIDOR_PAUSA_EN
    logic       pausa = 1'b0;
`endif

    logic [3:0] rom [16];

    int n_vec = 0;
    int n_err = 0;
    int e_cnt = 0;

    // Model state, written only by the stimulus process.
    bit         chk_en = 1'b0;
    bit         m_run = 1'b0;
    int         m_base = 0;
    logic [3:0] m_lim = 4'd0;
    logic [3:0] m_idle_addr = 4'd0;

    exibidor_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .limite       (limite),
`ifdef EXIBIDOR_PAUSA_EN
        .pausa        (pausa),
`endif
        .rom_endereco (rom_endereco),
        .rom_dado     (rom_dado),
        .leds         (leds),
        .exibindo     (exibindo),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data follows the registered address by one cycle.
    always @(posedge clock) rom_dado <= rom[rom_endereco];

    always @(posedge clock) e_cnt <= e_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare of {leds, rom_endereco, exibindo, pronto, db_estado}.
    int          c_d, c_k, c_off, c_n;
    logic [12:0] c_exp;
    always @(negedge clock) begin
        if (chk_en) begin
            c_n = int'(m_lim) + 1;
            c_d = e_cnt - m_base;
            if (m_run && c_d >= 1 && c_d <= c_n * P) begin
                c_k   = (c_d - 1) / P;
                c_off = (c_d - 1) % P;
                if (c_off == 0)
                    c_exp = {4'd0, 4'(c_k), 1'b1, 1'b0, 3'd1};
                else if (c_off == 1)
                    c_exp = {4'd0, 4'(c_k), 1'b1, 1'b0, 3'd2};
                else if (c_off < 2 + T_ON)
                    c_exp = {rom[c_k], 4'(c_k), 1'b1, 1'b0, 3'd3};
                else
                    c_exp = {4'd0, 4'(c_k), 1'b1, 1'b0, 3'd4};
            end else if (m_run && c_d == c_n * P + 1) begin
                c_exp = {4'd0, m_lim, 1'b0, 1'b1, 3'd5};
            end else if (m_run && c_d > c_n * P + 1) begin
                c_exp = {4'd0, m_lim, 5'd0};
            end else begin
                c_exp = {4'd0, m_idle_addr, 5'd0};
            end
            check("per_cycle", 32'({leds, rom_endereco, exibindo, pronto, db_estado}), 32'(c_exp));
        end
    end

    // Pulse iniciar for one edge and arm the model; returns at cycle 1.
    task automatic start_seq(input logic [3:0] lim);
        @(negedge clock);
        if (m_run) m_idle_addr = m_lim;
        iniciar = 1'b1;
        limite  = lim;
        m_lim   = lim;
        m_base  = e_cnt;
        m_run   = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // Advance to the negedge inside cycle d of the current run.
    task automatic at_cycle(input int d);
        int guard = 0;
        while ((e_cnt - m_base) < d && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 2000) check("at_cycle_timeout", 32'(e_cnt - m_base), 32'(d));
    endtask

    // Wait for pronto and report the cycle it appeared in (-1 on timeout).
    task automatic wait_pronto(output int d);
        d = -1;
        for (int i = 0; i < 300; i++) begin
            if (pronto === 1'b1) begin
                d = e_cnt - m_base;
                break;
            end
            @(negedge clock);
        end
    endtask

    int d_pronto;

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'(i * 5 + 3);
        rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4; rom[3] = 4'd8;

        // Reset behaviour
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'({leds, rom_endereco, exibindo, pronto, db_estado}), 32'd0);
        #2 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clock);

        // Nominal run, limite=3
        start_seq(4'd3);
        at_cycle(2);  check("nom_leds_c2", 32'(leds), 32'd0);
        at_cycle(3);  check("nom_leds_c3", 32'(leds), 32'd1);
        at_cycle(7);  check("nom_leds_c7", 32'(leds), 32'd0);
        at_cycle(10); check("nom_leds_c10", 32'(leds), 32'd2);
        at_cycle(24); check("nom_leds_c24", 32'(leds), 32'd8);
        at_cycle(28); check("nom_exib_c28", 32'(exibindo), 32'd1);
        wait_pronto(d_pronto);
        check("nom_pronto_cycle", 32'(d_pronto), 32'd29);
        repeat (3) @(negedge clock);

        // Zero data, single step
        rom[0] = 4'd0;
        start_seq(4'd0);
        at_cycle(3); check("zero_leds_c3", 32'(leds), 32'd0);
        wait_pronto(d_pronto);
        check("zero_pronto_cycle", 32'(d_pronto), 32'd8);
        repeat (2) @(negedge clock);
        rom[0] = 4'd1;

        // Full range, limite=15
        start_seq(4'd15);
        wait_pronto(d_pronto);
        check("full_pronto_cycle", 32'(d_pronto), 32'd113);
        check("full_addr_end", 32'(rom_endereco), 32'd15);
        repeat (3) @(negedge clock);
        check("full_addr_idle", 32'(rom_endereco), 32'd15);

        // Ignored iniciar/limite during a run
        start_seq(4'd3);
        at_cycle(10);
        iniciar = 1'b1;
        limite  = 4'd0;
        @(negedge clock);
        iniciar = 1'b0;
        wait_pronto(d_pronto);
        check("ign_pronto_cycle", 32'(d_pronto), 32'd29);
        check("ign_addr_end", 32'(rom_endereco), 32'd3);
        repeat (2) @(negedge clock);

        // Reset during ACENDE of step 2
        start_seq(4'd3);
        at_cycle(17);
        check("rst_pre_leds", 32'(leds), 32'd4);
        #2 reset = 1'b0;
        m_run = 1'b0;
        m_idle_addr = 4'd0;
        #1 check("rst_async", 32'({leds, exibindo, pronto, db_estado}), 32'd0);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        repeat (2) @(negedge clock);
        start_seq(4'd1);
        at_cycle(3); check("rst_restart_leds", 32'(leds), 32'd1);
        wait_pronto(d_pronto);
        check("rst_restart_pronto", 32'(d_pronto), 32'd15);
        repeat (2) @(negedge clock);

`ifdef EXIBIDOR_PAUSA_EN
        // Pause for 5 cycles in ACENDE of step 0
        chk_en = 1'b0;
        start_seq(4'd3);
        at_cycle(3);  pausa = 1'b1;
        at_cycle(8);  pausa = 1'b0;
        check("pause_leds_c8", 32'(leds), 32'd1);
        at_cycle(10); check("pause_leds_c10", 32'(leds), 32'd1);
        at_cycle(11); check("pause_leds_c11", 32'(leds), 32'd0);
        wait_pronto(d_pronto);
        check("pause_pronto_cycle", 32'(d_pronto), 32'd34);
        repeat (2) @(negedge clock);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exibidor_sequencia.md
Name: exibidor_sequencia

Overview:
- Presents the stored game sequence to the player before each round: reads the sequence ROM from address 0 up to a latched limit.
- Lights the LEDs with each stored value for T_ON cycles, blanks them for T_OFF cycles, then signals completion.
- Opposite end of the player-input path. That path compares button presses against the ROM; this block drives the ROM contents out to the LEDs.
- Sits between the game controller (start/done handshake) and the sync_rom_16x4 instance it shares with the datapath.

Parameters:
- T_ON, 500, LED-lit cycles per step (0.5 s at 1 kHz); must be >= 1.
- T_OFF, 250, LED-dark cycles after each step; must be >= 1.
- CNT_W, 10, timer width; must satisfy 2^CNT_W > max(T_ON, T_OFF).

Ports:
- clock  in  1  system clock (1 kHz in the game build).
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request, sampled on rising edge while idle.
- limite  in  4  last ROM address to show, inclusive; latched on start.
- rom_endereco  out  4  address to the synchronous ROM.
- rom_dado  in  4  ROM data, valid one cycle after the address is registered.
- leds  out  4  LED drive.
- exibindo  out  1  high from start acceptance until pronto.
- pronto  out  1  one-cycle completion pulse.
- db_estado  out  3  current state encoding, for debug.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While reset is low: state OCIOSO; leds=0, rom_endereco=0, exibindo=0, pronto=0, timer=0, internal limit and data registers = 0.
- States and db_estado codes: OCIOSO=0, LE_ROM=1, ESPERA_ROM=2, ACENDE=3, APAGA=4, FIM=5. Codes 6 and 7 are illegal and go to OCIOSO on the next edge.
- OCIOSO:
  - iniciar=1 on an edge → rom_endereco<=0, limite latched, exibindo<=1, next state LE_ROM.
  - Otherwise stay in OCIOSO.
- LE_ROM: one cycle. The ROM samples rom_endereco on the exiting edge. Next state ESPERA_ROM.
- ESPERA_ROM: one cycle. rom_dado is captured into the data register on the exiting edge; timer<=0. Next state ACENDE.
- ACENDE:
  - leds = captured data for exactly T_ON cycles; timer increments each cycle.
  - When timer==T_ON-1: timer<=0, next state APAGA.
- APAGA:
  - leds=0 for exactly T_OFF cycles.
  - When timer==T_OFF-1:
    - if rom_endereco==latched limit → FIM;
    - else rom_endereco<=rom_endereco+1 → LE_ROM.
- FIM: one cycle with pronto=1 and exibindo=0, then OCIOSO.
- Latency: if iniciar is sampled at edge 0, leds first show data during cycle 3.
- Each step lasts 2+T_ON+T_OFF cycles. pronto is asserted in cycle (limite+1)*(2+T_ON+T_OFF)+1.
- leds is 0 outside ACENDE, including when the stored value is 0. A zero step still occupies its full time slot.
- iniciar and limite changes while not in OCIOSO are ignored.
- limite=15 shows all 16 addresses. The address never wraps because the limit compare terminates first.
- Reset asserted mid-sequence immediately forces OCIOSO with all outputs 0. No pronto is generated.
- iniciar held high is accepted again in the cycle after FIM, since OCIOSO samples it.

Optional Feature:
- Macro: EXIBIDOR_PAUSA_EN.
- Defined:
  - Adds input port pausa (1 bit).
  - While pausa=1 in ACENDE or APAGA, the timer and state freeze and leds holds its current value.
  - LE_ROM, ESPERA_ROM and FIM are not affected by pausa.
  - Releasing pausa resumes counting from the frozen value.
- Undefined: port pausa is absent; timers run unconditionally.

Test Plan:
- Reset behaviour: T_ON=3, T_OFF=2, ROM[0..3]=1,2,4,8, reset low then high → all outputs 0, db_estado=0.
- Nominal run: limite=3, iniciar pulse at edge 0 → leds=1 in cycles 3-5, 0 in cycles 6-7, then 2, 4, 8 at 7-cycle spacing; pronto=1 only in cycle 29; exibindo high in cycles 1-28.
- Zero data and full range: limite=0 with ROM[0]=0 → leds stays 0, pronto in cycle 8. Separately, limite=15 → 16 steps, rom_endereco reaches 15 and does not wrap, pronto in cycle 113.
- Ignored inputs: iniciar re-pulsed and limite changed to 0 during step 1 → sequence still runs to address 3, with no restart.
- Reset mid-run: reset low during ACENDE of step 2 → leds=0, exibindo=0, db_estado=0 immediately; no pronto pulse; a fresh iniciar restarts at address 0.
- Pause (EXIBIDOR_PAUSA_EN): pausa=1 for 5 cycles in ACENDE of step 0 → leds=1 lasts 8 cycles total; the pronto cycle shifts by +5.
